// File: rtl/sw_result_serializer.sv
// sw_result_serializer: buffers Smith-Waterman core results in a small FIFO and
// streams each one out as a fixed-length, MSB-first byte frame over a
// valid/ready byte interface.
module sw_result_serializer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int FRAME_BYTES = 31
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [9:0]                    i_alignment_score,
  input  logic [6:0]                    i_column,
  input  logic [6:0]                    i_row,
  output logic                          o_byte_valid,
  input  logic                          i_byte_ready,
  output logic [7:0]                    o_byte,
  output logic                          o_frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int CW      = $clog2(FRAME_BYTES) + 1;
  localparam int FRAME_W = 248;

  typedef struct packed {
    logic [9:0] score;
    logic [6:0] col;
    logic [6:0] row;
  } entry_t;

  typedef enum logic {IDLE, SEND} state_t;

  entry_t              mem_q [FIFO_DEPTH];
  logic [PW-1:0]       wptr_q, rptr_q;
  logic [PW:0]         count_q, count_d;
  state_t              state_q;
  logic [FRAME_W-1:0]  frame_q;
  logic [CW-1:0]       bcnt_q;

  logic                push, pop, hs, last_byte;
  entry_t              head;
  logic [FRAME_W-1:0]  frame_load;

  // Readiness comes from the registered count only, so a pop in the same
  // cycle never lets a full FIFO take a new entry.
  assign o_ready      = (count_q < (PW+1)'(FIFO_DEPTH));
  assign push         = i_valid && o_ready;
  assign pop          = (state_q == IDLE) && (count_q != '0);
  assign o_byte_valid = (state_q == SEND);
  assign hs           = o_byte_valid && i_byte_ready;
  assign last_byte    = (bcnt_q == CW'(FRAME_BYTES - 1));
  assign o_frame_done = hs && last_byte;
  assign o_byte       = frame_q[FRAME_W-1 -: 8];
  assign o_fifo_count = count_q;

  // Head entry laid out as the zero-extended wire frame.
  assign head       = mem_q[rptr_q];
  assign frame_load = {113'b0, head.col, 57'b0, head.row, 54'b0, head.score};

  // Occupancy next-state: push and pop together cancel.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= '{score: i_alignment_score, col: i_column, row: i_row};
  end

  // FIFO pointers and count; pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Frame FSM: load a frame from the FIFO head in IDLE, shift it out in SEND.
  // The final handshake leaves the frame unshifted so o_byte holds the last
  // byte sent while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      bcnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            frame_q <= frame_load;
            bcnt_q  <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (i_byte_ready) begin
            if (last_byte) begin
              state_q <= IDLE;
            end else begin
              frame_q <= {frame_q[FRAME_W-9:0], 8'h00};
              bcnt_q  <= bcnt_q + CW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sw_result_serializer.sv
// Self-checking bench for sw_result_serializer: a scoreboard queue of
// expected frame bytes is filled on each accepted push and drained by a
// monitor that compares every byte handshake.
module tb_sw_result_serializer;

  localparam int FIFO_DEPTH  = 4;
  localparam int FRAME_BYTES = 31;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid;
  logic       o_ready;
  logic [9:0] i_alignment_score;
  logic [6:0] i_column;
  logic [6:0] i_row;
  logic       o_byte_valid;
  logic       i_byte_ready;
  logic [7:0] o_byte;
  logic       o_frame_done;
  logic [2:0] o_fifo_count;

  typedef struct {
    logic [7:0] b;
    bit         last;
  } exp_t;

  exp_t exp_q[$];
  int   errors      = 0;
  int   checks      = 0;
  int   frames_seen = 0;

  sw_result_serializer #(.FIFO_DEPTH(FIFO_DEPTH), .FRAME_BYTES(FRAME_BYTES)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_valid           (i_valid),
    .o_ready           (o_ready),
    .i_alignment_score (i_alignment_score),
    .i_column          (i_column),
    .i_row             (i_row),
    .o_byte_valid      (o_byte_valid),
    .i_byte_ready      (i_byte_ready),
    .o_byte            (o_byte),
    .o_frame_done      (o_frame_done),
    .o_fifo_count      (o_fifo_count)
  );

  always #5 clk = ~clk;

  // Reference frame: column in byte 14, row in byte 22, score in bytes 29..30.
  function automatic logic [7:0] exp_byte(input int k, input logic [9:0] s,
                                          input logic [6:0] c, input logic [6:0] r);
    case (k)
      14:      return {1'b0, c};
      22:      return {1'b0, r};
      29:      return {6'b0, s[9:8]};
      30:      return s[7:0];
      default: return 8'h00;
    endcase
  endfunction

  // Monitor: compares handshakes against the scoreboard, checks stall
  // stability, the 31-handshake frame length and the idle gap after a frame.
  task automatic monitor_loop();
    bit         prev_stall = 0;
    bit         gap_chk    = 0;
    logic [7:0] prev_byte  = 8'h00;
    int         hs_cnt     = 0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
        gap_chk    = 0;
        hs_cnt     = 0;
      end else begin
        if (gap_chk) begin
          checks++;
          if (o_byte_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_gap: o_byte_valid=%b required 0", o_byte_valid);
          end
          gap_chk = 0;
        end
        if (prev_stall && o_byte_valid) begin
          checks++;
          if (o_byte !== prev_byte) begin
            errors++;
            $display("FAIL stall_hold: o_byte=%02h required %02h", o_byte, prev_byte);
          end
        end
        if (o_byte_valid && i_byte_ready) begin
          hs_cnt++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_byte: o_byte=%02h with empty scoreboard", o_byte);
          end else begin
            e = exp_q.pop_front();
            if (o_byte !== e.b) begin
              errors++;
              $display("FAIL byte_value: o_byte=%02h required %02h (handshake %0d)", o_byte, e.b, hs_cnt);
            end
            checks++;
            if (o_frame_done !== e.last) begin
              errors++;
              $display("FAIL frame_done: o_frame_done=%b required %b (handshake %0d)", o_frame_done, e.last, hs_cnt);
            end
            if (e.last) begin
              checks++;
              if (hs_cnt !== FRAME_BYTES) begin
                errors++;
                $display("FAIL frame_len: handshakes=%0d required %0d", hs_cnt, FRAME_BYTES);
              end
              hs_cnt = 0;
              frames_seen++;
              gap_chk = 1;
            end
          end
        end else begin
          checks++;
          if (o_frame_done !== 1'b0) begin
            errors++;
            $display("FAIL frame_done_idle: o_frame_done=%b required 0", o_frame_done);
          end
        end
      end
      prev_stall = o_byte_valid && !i_byte_ready && !rst;
      prev_byte  = o_byte;
    end
  endtask

  // Drive one result; returns after the accepting edge (+1) with the number of
  // edges it had to wait. Expected bytes enter the scoreboard on acceptance.
  task automatic push_result(input logic [9:0] s, input logic [6:0] c,
                             input logic [6:0] r, output int waited);
    bit acc = 0;
    i_valid = 1'b1; i_alignment_score = s; i_column = c; i_row = r;
    waited = 0;
    for (int n = 0; n < 500 && !acc; n++) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk); #1;
      if (!acc) waited++;
    end
    i_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL push_timeout: result not accepted within 500 cycles");
    end else begin
      for (int k = 0; k < FRAME_BYTES; k++)
        exp_q.push_back('{b: exp_byte(k, s, c, r), last: (k == FRAME_BYTES - 1)});
    end
  endtask

  // Run until the scoreboard and the FIFO are empty and the FSM is idle.
  task automatic wait_drain(input bit rnd);
    bit done = 0;
    for (int n = 0; n < 4000 && !done; n++) begin
      @(posedge clk); #1;
      i_byte_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      done = (exp_q.size() == 0) && !o_byte_valid && (o_fifo_count == 0);
    end
    i_byte_ready = 1'b1;
    if (!done) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d bytes still expected", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; i_byte_ready = 1'b0;
    i_alignment_score = '0; i_column = '0; i_row = '0;
    #3;
    checks++; if (o_byte_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", o_byte_valid); end
    checks++; if (o_byte !== 8'h00)      begin errors++; $display("FAIL rst_byte: got %02h required 00", o_byte); end
    checks++; if (o_frame_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b required 0", o_frame_done); end
    checks++; if (o_fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d required 0", o_fifo_count); end
    checks++; if (o_ready !== 1'b1)      begin errors++; $display("FAIL rst_ready: got %b required 1", o_ready); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_single();
    int w;
    i_byte_ready = 1'b1;
    push_result(10'd37, 7'd5, 7'd9, w);
    checks++; if (o_byte_valid !== 1'b0) begin errors++; $display("FAIL lat_n: o_byte_valid=%b required 0", o_byte_valid); end
    checks++; if (o_fifo_count !== 3'd1) begin errors++; $display("FAIL lat_count: got %0d required 1", o_fifo_count); end
    @(posedge clk); #1;
    checks++; if (o_byte_valid !== 1'b1) begin errors++; $display("FAIL lat_n1: o_byte_valid=%b required 1", o_byte_valid); end
    checks++; if (o_fifo_count !== 3'd0) begin errors++; $display("FAIL pop_count: got %0d required 0", o_fifo_count); end
    wait_drain(0);
    checks++; if (o_byte !== 8'h25) begin errors++; $display("FAIL idle_hold: o_byte=%02h required 25", o_byte); end
  endtask

  task automatic test_max();
    int w;
    int f0 = frames_seen;
    push_result(10'd1023, 7'd127, 7'd127, w);
    wait_drain(0);
    checks++; if (frames_seen !== f0 + 1) begin errors++; $display("FAIL max_frames: got %0d required %0d", frames_seen - f0, 1); end
  endtask

  task automatic test_stalls();
    int w;
    int f0 = frames_seen;
    i_byte_ready = 1'b0;
    push_result(10'd600, 7'd64, 7'd3, w);
    push_result(10'd255, 7'd1,  7'd100, w);
    push_result(10'd256, 7'd77, 7'd0, w);
    wait_drain(1);
    checks++; if (frames_seen !== f0 + 3) begin errors++; $display("FAIL stall_frames: got %0d required 3", frames_seen - f0); end
  endtask

  task automatic test_full_pop();
    int  w;
    bit  acc = 0;
    logic [9:0] sv [5] = '{10'd11, 10'd22, 10'd33, 10'd44, 10'd55};
    i_byte_ready = 1'b0;
    push_result(10'd500, 7'd50, 7'd60, w);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) push_result(sv[i], 7'(i + 1), 7'(i + 20), w);
    checks++; if (o_fifo_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d required 4", o_fifo_count); end
    checks++; if (o_ready !== 1'b0)      begin errors++; $display("FAIL full_ready: got %b required 0", o_ready); end
    // Fifth result is offered while full, including on the popping edge.
    i_valid = 1'b1; i_alignment_score = sv[4]; i_column = 7'd5; i_row = 7'd24;
    i_byte_ready = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      if (o_ready) begin
        acc = 1;
        checks++;
        if (o_fifo_count !== 3'd3) begin errors++; $display("FAIL pop_while_full: count=%0d required 3", o_fifo_count); end
      end
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++; $display("FAIL fifth_timeout: fifth result never accepted");
    end else begin
      for (int k = 0; k < FRAME_BYTES; k++)
        exp_q.push_back('{b: exp_byte(k, sv[4], 7'd5, 7'd24), last: (k == FRAME_BYTES - 1)});
      if (o_fifo_count !== 3'd4) begin errors++; $display("FAIL fifth_count: got %0d required 4", o_fifo_count); end
    end
    wait_drain(0);
  endtask

  task automatic test_reset_mid_frame();
    int w;
    int hs = 0;
    bit seen = 0;
    i_byte_ready = 1'b0;
    push_result(10'd7, 7'd8, 7'd9, w);
    push_result(10'd70, 7'd80, 7'd90, w);
    push_result(10'd700, 7'd81, 7'd91, w);
    checks++; if (o_fifo_count !== 3'd2) begin errors++; $display("FAIL queued_count: got %0d required 2", o_fifo_count); end
    i_byte_ready = 1'b1;
    for (int n = 0; n < 100 && hs < 12; n++) begin
      @(negedge clk);
      if (o_byte_valid && i_byte_ready) hs++;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    checks++; if (o_byte_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b required 0", o_byte_valid); end
    checks++; if (o_fifo_count !== 3'd0) begin errors++; $display("FAIL midrst_count: got %0d required 0", o_fifo_count); end
    checks++; if (o_ready !== 1'b1)      begin errors++; $display("FAIL midrst_ready: got %b required 1", o_ready); end
    checks++; if (o_byte !== 8'h00)      begin errors++; $display("FAIL midrst_byte: got %02h required 00", o_byte); end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (o_byte_valid) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL resend_after_rst: o_byte_valid=1 required 0"); end
    // First edge after release must accept a push.
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    push_result(10'd99, 7'd10, 7'd11, w);
    checks++; if (w !== 0)               begin errors++; $display("FAIL first_push_wait: waited=%0d required 0", w); end
    checks++; if (o_fifo_count !== 3'd1) begin errors++; $display("FAIL first_push_count: got %0d required 1", o_fifo_count); end
    wait_drain(0);
  endtask

  initial begin
    fork
      monitor_loop();
    join_none
    test_reset();
    test_single();
    test_max();
    test_stalls();
    test_full_pop();
    test_reset_mid_frame();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
